dpwm_sched: RTL and testbench

Sequencing and duty-distribution controller for the N-cell interleaved FCML DPWM bank. It holds the DPWM instances in reset while their ramps arm and drives the per-cell interleave angles. It then soft-starts the shared duty from zero to the commanded value, hands off to closed-loop duty updates, and latches faults to force all cells off. Duty commands change the DPWM bank only on a cell-0 ramp zero crossing, so a PWM period never sees a mid-period duty change.

---
 rtl/dpwm_sched_pkg.sv | 25 ++
 rtl/dpwm_sched_if.sv | 11 +
 rtl/dpwm_sched_softstart_ramp.sv | 43 ++++
 rtl/dpwm_sched.sv | 178 +++++++++++++++++
 tb/tb_dpwm_sched.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dpwm_sched_pkg.sv
// Shared width, FSM encoding and elaboration-time helpers for the DPWM scheduler.
package dpwm_pkg;

  localparam int W = 11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    SOFT  = 3'd2,
    RUN   = 3'd3,
    FAULT = 3'd4
  } state_t;

  function automatic logic [W-1:0] angle_of(input int i, input int period, input int n_cells);
    return W'((i * period) / n_cells);
  endfunction

  // Saturate rather than wrap: an out-of-range command must never alias to a small duty.
  function automatic logic [W-1:0] clamp_duty(input logic [W-1:0] v, input int dmin, input int dmax);
    if (int'(v) < dmin) return W'(dmin);
    if (int'(v) > dmax) return W'(dmax);
    return v;
  endfunction

endpackage

// File: rtl/dpwm_sched_if.sv
// Duty-command valid/ready handshake between the control loop and the DPWM scheduler.
interface dpwm_sched_if;
  import dpwm_pkg::*;

  logic [W-1:0] duty_cmd;
  logic         duty_valid;
  logic         duty_ready;

  modport master (output duty_cmd, output duty_valid, input duty_ready);
  modport slave  (input duty_cmd, input duty_valid, output duty_ready);
endinterface

// File: rtl/dpwm_sched_softstart_ramp.sv
// Soft-start ramp: steps the shared duty by SS_STEP every SS_DIV ticks, saturating at target.
module softstart_ramp
  import dpwm_pkg::*;
#(
  parameter int SS_DIV  = 16,
  parameter int SS_STEP = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         tick,
  input  logic [W-1:0] target,
  output logic [W-1:0] ss_next,
  output logic         step_due,
  output logic         done
);
  localparam int DW = (SS_DIV > 1) ? $clog2(SS_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SS_DIV - 1);

  logic [DW-1:0] div_cnt_reg;
  logic [W-1:0]  ss_reg;
  logic [W:0]    sum_next;

  // One extra bit so a ramp near full scale cannot wrap before the min.
  assign sum_next = {1'b0, ss_reg} + (W+1)'(SS_STEP);
  assign ss_next  = (sum_next < {1'b0, target}) ? sum_next[W-1:0] : target;
  assign step_due = (div_cnt_reg == DIV_LAST);
  assign done     = (ss_reg == target);

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      div_cnt_reg <= '0;
      ss_reg      <= '0;
    end else if (tick) begin
      if (step_due) begin
        div_cnt_reg <= '0;
        ss_reg      <= ss_next;
      end else begin
        div_cnt_reg <= div_cnt_reg + 1'b1;
      end
    end
  end
endmodule

// File: rtl/dpwm_sched.sv
// Sequencer for the interleaved DPWM bank: arm, soft-start, closed-loop run, latched fault.
module dpwm_sched
  import dpwm_pkg::*;
#(
  parameter int N_CELLS  = 4,
  parameter int PERIOD   = 2000,
  parameter int DUTY_MIN = 0,
  parameter int DUTY_MAX = 1900,
  parameter int SS_DIV   = 16,
  parameter int SS_STEP  = 8,
  parameter int ARM_CYC  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 fault_in,
  input  logic                 sync_zero,
  dpwm_sched_if.slave          cmd_if,
  output logic                 dpwm_rst,
  output logic [N_CELLS*W-1:0] dpwm_duty,
  output logic [N_CELLS*W-1:0] dpwm_angle,
  output logic                 gate_en,
  output logic [2:0]           state,
  output logic                 fault_latched
);
  localparam int AW = (ARM_CYC > 1) ? $clog2(ARM_CYC) : 1;
  localparam logic [AW-1:0] ARM_LAST = AW'(ARM_CYC - 1);

  state_t        state_reg;
  logic [AW-1:0] arm_cnt_reg;
  logic [W-1:0]  target_reg, pend_duty_reg, duty_reg;
  logic          pending_reg, duty_ready_reg, dpwm_rst_reg, gate_en_reg, fault_latched_reg;

  logic          accept, arm_load, ramp_clear, ramp_tick;
  logic [W-1:0]  cmd_clamped, ss_next;
  logic          ss_step_due, ss_done;

  assign accept      = cmd_if.duty_valid && duty_ready_reg;
  assign cmd_clamped = clamp_duty(cmd_if.duty_cmd, DUTY_MIN, DUTY_MAX);
  assign arm_load    = (state_reg == IDLE) && en && !fault_in;
  assign ramp_clear  = (state_reg != SOFT);
  assign ramp_tick   = (state_reg == SOFT) && sync_zero && !ss_done;

  softstart_ramp #(.SS_DIV(SS_DIV), .SS_STEP(SS_STEP)) u_ramp (
    .clk      (clk),
    .rst      (rst),
    .clear    (ramp_clear),
    .tick     (ramp_tick),
    .target   (target_reg),
    .ss_next  (ss_next),
    .step_due (ss_step_due),
    .done     (ss_done)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg         <= IDLE;
      arm_cnt_reg       <= '0;
      target_reg        <= '0;
      pend_duty_reg     <= '0;
      duty_reg          <= '0;
      pending_reg       <= 1'b0;
      duty_ready_reg    <= 1'b0;
      dpwm_rst_reg      <= 1'b1;
      gate_en_reg       <= 1'b0;
      fault_latched_reg <= 1'b0;
    end else if (fault_in) begin
      state_reg         <= FAULT;
      duty_reg          <= '0;
      pending_reg       <= 1'b0;
      duty_ready_reg    <= 1'b0;
      dpwm_rst_reg      <= 1'b1;
      gate_en_reg       <= 1'b0;
      fault_latched_reg <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) target_reg <= cmd_clamped;
          dpwm_rst_reg <= 1'b1;
          gate_en_reg  <= 1'b0;
          duty_reg     <= '0;
          if (en) begin
            state_reg      <= ARM;
            arm_cnt_reg    <= '0;
            duty_ready_reg <= 1'b0;
          end else begin
            duty_ready_reg <= 1'b1;
          end
        end
        ARM: begin
          if (!en) begin
            state_reg      <= IDLE;
            duty_ready_reg <= 1'b1;
          end else if (arm_cnt_reg == ARM_LAST) begin
            state_reg      <= SOFT;
            dpwm_rst_reg   <= 1'b0;
            gate_en_reg    <= 1'b1;
            duty_reg       <= '0;
            duty_ready_reg <= 1'b1;
          end else begin
            arm_cnt_reg <= arm_cnt_reg + 1'b1;
          end
        end
        SOFT: begin
          if (accept) target_reg <= cmd_clamped;
          if (!en) begin
            state_reg      <= IDLE;
            dpwm_rst_reg   <= 1'b1;
            gate_en_reg    <= 1'b0;
            duty_reg       <= '0;
            duty_ready_reg <= 1'b1;
          end else if (sync_zero) begin
            if (ss_done) begin
              state_reg   <= RUN;
              pending_reg <= 1'b0;
            end else if (ss_step_due) begin
              duty_reg <= ss_next;
            end
          end
        end
        RUN: begin
          if (!en) begin
            state_reg      <= IDLE;
            dpwm_rst_reg   <= 1'b1;
            gate_en_reg    <= 1'b0;
            duty_reg       <= '0;
            pending_reg    <= 1'b0;
            duty_ready_reg <= 1'b1;
          end else if (sync_zero && pending_reg) begin
            duty_reg       <= pend_duty_reg;
            pending_reg    <= 1'b0;
            duty_ready_reg <= 1'b1;
          end else if (accept) begin
            // A command arriving with sync_zero waits for the next zero crossing.
            pend_duty_reg  <= cmd_clamped;
            pending_reg    <= 1'b1;
            duty_ready_reg <= 1'b0;
          end
        end
        FAULT: begin
          if (!en) begin
            state_reg         <= IDLE;
            fault_latched_reg <= 1'b0;
            duty_ready_reg    <= 1'b1;
          end
        end
        default: begin
          state_reg         <= FAULT;
          duty_reg          <= '0;
          pending_reg       <= 1'b0;
          duty_ready_reg    <= 1'b0;
          dpwm_rst_reg      <= 1'b1;
          gate_en_reg       <= 1'b0;
          fault_latched_reg <= 1'b1;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < N_CELLS; gi++) begin : g_cell
    localparam logic [W-1:0] ANGLE = angle_of(gi, PERIOD, N_CELLS);
    logic [W-1:0] angle_reg;

    always_ff @(posedge clk) begin
      if (!rst) angle_reg <= '0;
      else if (arm_load) angle_reg <= ANGLE;
    end

    assign dpwm_angle[gi*W +: W] = angle_reg;
    assign dpwm_duty[gi*W +: W]  = duty_reg;
  end

  assign cmd_if.duty_ready = duty_ready_reg;
  assign dpwm_rst          = dpwm_rst_reg;
  assign gate_en           = gate_en_reg;
  assign state             = state_reg;
  assign fault_latched     = fault_latched_reg;
endmodule

// File: tb/tb_dpwm_sched.sv
// Self-checking bench for dpwm_sched against closed-form soft-start and handshake rules.
module tb_dpwm_sched;
  import dpwm_pkg::*;

  localparam int N_CELLS  = 4;
  localparam int PERIOD   = 2000;
  localparam int DUTY_MIN = 0;
  localparam int DUTY_MAX = 1900;
  localparam int SS_DIV   = 16;
  localparam int SS_STEP  = 8;
  localparam int ARM_CYC  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic fault_in = 1'b0;
  logic sync_zero = 1'b0;
  logic                 dpwm_rst, gate_en, fault_latched;
  logic [2:0]           state;
  logic [N_CELLS*W-1:0] dpwm_duty, dpwm_angle;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_duty = 0;
  int tgt_model = 0;

  dpwm_sched_if cmd_if ();

  always #5 clk = ~clk;

  dpwm_sched #(
    .N_CELLS(N_CELLS), .PERIOD(PERIOD), .DUTY_MIN(DUTY_MIN), .DUTY_MAX(DUTY_MAX),
    .SS_DIV(SS_DIV), .SS_STEP(SS_STEP), .ARM_CYC(ARM_CYC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .fault_in      (fault_in),
    .sync_zero     (sync_zero),
    .cmd_if        (cmd_if.slave),
    .dpwm_rst      (dpwm_rst),
    .dpwm_duty     (dpwm_duty),
    .dpwm_angle    (dpwm_angle),
    .gate_en       (gate_en),
    .state         (state),
    .fault_latched (fault_latched)
  );

  function automatic int clamp_ref(input int v);
    if (v < DUTY_MIN) return DUTY_MIN;
    if (v > DUTY_MAX) return DUTY_MAX;
    return v;
  endfunction

  // Shared duty after k sync_zero pulses in soft-start, straight from the ramp rule.
  function automatic int ss_ref(input int k, input int tgt);
    int raw;
    raw = (k / SS_DIV) * SS_STEP;
    return (raw < tgt) ? raw : tgt;
  endfunction

  function automatic int cell_duty(input int i);
    return int'(dpwm_duty[i*W +: W]);
  endfunction

  function automatic int cell_angle(input int i);
    return int'(dpwm_angle[i*W +: W]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_sync();
    sync_zero = 1'b1;
    step();
    sync_zero = 1'b0;
  endtask

  task automatic send_cmd(input int cmd);
    cmd_if.duty_cmd   = W'(cmd);
    cmd_if.duty_valid = 1'b1;
    step();
    cmd_if.duty_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; fault_in = 1'b0; sync_zero = 1'b0;
    cmd_if.duty_valid = 1'b0; cmd_if.duty_cmd = '0;
    idle(2);
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++; if (dpwm_rst !== 1'b1) begin n_bad++; $display("FAIL reset_dpwm_rst: got %b want 1", dpwm_rst); end
    n_cmp++; if (gate_en !== 1'b0) begin n_bad++; $display("FAIL reset_gate_en: got %b want 0", gate_en); end
    n_cmp++; if (cmd_if.duty_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", cmd_if.duty_ready); end
    n_cmp++; if (fault_latched !== 1'b0) begin n_bad++; $display("FAIL reset_fault_latched: got %b want 0", fault_latched); end
    n_cmp++; if (dpwm_duty !== '0) begin n_bad++; $display("FAIL reset_duty: got %h want 0", dpwm_duty); end
    n_cmp++; if (dpwm_angle !== '0) begin n_bad++; $display("FAIL reset_angle: got %h want 0", dpwm_angle); end
    rst = 1'b1;
    step();
    n_cmp++; if (cmd_if.duty_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready: got %b want 1", cmd_if.duty_ready); end
    $display("reset: released, state=%0d ready=%b", state, cmd_if.duty_ready);
  endtask

  task automatic test_softstart(input int tgt);
    int arm_cycles;
    int kmax;
    int exp_state;
    tgt_model = clamp_ref(tgt);
    send_cmd(tgt);
    $display("softstart: target cmd %0d accepted in IDLE", tgt);
    en = 1'b1;
    step();
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL arm_entry_state: got %0d want 1", state); end
    arm_cycles = 0;
    for (int c = 0; c < ARM_CYC + 4 && state == 3'd1; c++) begin
      if (dpwm_rst === 1'b1) arm_cycles++;
      step();
    end
    n_cmp++; if (arm_cycles != ARM_CYC) begin n_bad++; $display("FAIL arm_hold_cycles: got %0d want %0d", arm_cycles, ARM_CYC); end
    n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL soft_entry_state: got %0d want 2", state); end
    n_cmp++; if (gate_en !== 1'b1) begin n_bad++; $display("FAIL soft_gate_en: got %b want 1", gate_en); end
    n_cmp++; if (dpwm_rst !== 1'b0) begin n_bad++; $display("FAIL soft_dpwm_rst: got %b want 0", dpwm_rst); end
    for (int i = 0; i < N_CELLS; i++) begin
      n_cmp++;
      if (cell_angle(i) != (i * PERIOD) / N_CELLS) begin
        n_bad++; $display("FAIL angle_cell%0d: got %0d want %0d", i, cell_angle(i), (i * PERIOD) / N_CELLS);
      end
    end
    kmax = ((tgt_model + SS_STEP - 1) / SS_STEP) * SS_DIV + 1;
    for (int k = 1; k <= kmax; k++) begin
      idle(3);
      pulse_sync();
      exp_state = (((k - 1) / SS_DIV) * SS_STEP >= tgt_model) ? 3 : 2;
      n_cmp++;
      if (int'(state) != exp_state) begin
        n_bad++; $display("FAIL soft_state_pulse%0d: got %0d want %0d", k, state, exp_state);
      end
      for (int i = 0; i < N_CELLS; i++) begin
        n_cmp++;
        if (cell_duty(i) != ss_ref(k, tgt_model)) begin
          n_bad++; $display("FAIL soft_duty_pulse%0d_cell%0d: got %0d want %0d", k, i, cell_duty(i), ss_ref(k, tgt_model));
        end
      end
    end
    exp_duty = tgt_model;
    $display("softstart: %0d pulses, state=%0d duty=%0d", kmax, state, cell_duty(0));
  endtask

  task automatic test_run_cmds();
    int cmds[8];
    int ready_seen;
    cmds[0] = 1000; cmds[1] = 2047; cmds[2] = 0; cmds[3] = 1900; cmds[4] = 1901;
    cmds[5] = int'($urandom_range(0, 2047));
    cmds[6] = int'($urandom_range(0, 2047));
    cmds[7] = int'($urandom_range(0, 2047));
    for (int n = 0; n < 8; n++) begin
      idle(int'($urandom_range(0, 3)));
      ready_seen = int'(cmd_if.duty_ready);
      n_cmp++; if (ready_seen != 1) begin n_bad++; $display("FAIL run_ready_before%0d: got %0d want 1", n, ready_seen); end
      // Command 2 arrives together with sync_zero and must wait for the next one.
      sync_zero = (n == 2);
      send_cmd(cmds[n]);
      sync_zero = 1'b0;
      $display("run: cmd %0d accepted, expect %0d", cmds[n], clamp_ref(cmds[n]));
      n_cmp++; if (cmd_if.duty_ready !== 1'b0) begin n_bad++; $display("FAIL run_ready_after%0d: got %b want 0", n, cmd_if.duty_ready); end
      n_cmp++; if (cell_duty(0) != exp_duty) begin n_bad++; $display("FAIL run_hold%0d: got %0d want %0d", n, cell_duty(0), exp_duty); end
      send_cmd((cmds[n] + 777) % 2048);
      idle(2);
      n_cmp++; if (cell_duty(3) != exp_duty) begin n_bad++; $display("FAIL run_midperiod%0d: got %0d want %0d", n, cell_duty(3), exp_duty); end
      pulse_sync();
      exp_duty = clamp_ref(cmds[n]);
      for (int i = 0; i < N_CELLS; i++) begin
        n_cmp++;
        if (cell_duty(i) != exp_duty) begin
          n_bad++; $display("FAIL run_apply%0d_cell%0d: got %0d want %0d", n, i, cell_duty(i), exp_duty);
        end
      end
      n_cmp++; if (cmd_if.duty_ready !== 1'b1) begin n_bad++; $display("FAIL run_ready_release%0d: got %b want 1", n, cmd_if.duty_ready); end
      n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL run_state%0d: got %0d want 3", n, state); end
    end
  endtask

  task automatic test_fault();
    en = 1'b0;
    step();
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL disable_state: got %0d want 0", state); end
    n_cmp++; if (gate_en !== 1'b0) begin n_bad++; $display("FAIL disable_gate_en: got %b want 0", gate_en); end
    n_cmp++; if (dpwm_duty !== '0) begin n_bad++; $display("FAIL disable_duty: got %h want 0", dpwm_duty); end
    n_cmp++; if (cmd_if.duty_ready !== 1'b1) begin n_bad++; $display("FAIL disable_ready: got %b want 1", cmd_if.duty_ready); end
    en = 1'b1;
    step();
    idle(ARM_CYC);
    n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL fault_pre_soft: got %0d want 2", state); end
    for (int k = 0; k < SS_DIV; k++) begin
      idle(1);
      pulse_sync();
    end
    n_cmp++; if (cell_duty(2) != ss_ref(SS_DIV, tgt_model)) begin n_bad++; $display("FAIL fault_pre_duty: got %0d want %0d", cell_duty(2), ss_ref(SS_DIV, tgt_model)); end
    fault_in = 1'b1;
    step();
    fault_in = 1'b0;
    $display("fault: pulse during SOFT, state=%0d gate_en=%b", state, gate_en);
    n_cmp++; if (state !== 3'd4) begin n_bad++; $display("FAIL fault_state: got %0d want 4", state); end
    n_cmp++; if (gate_en !== 1'b0) begin n_bad++; $display("FAIL fault_gate_en: got %b want 0", gate_en); end
    n_cmp++; if (dpwm_duty !== '0) begin n_bad++; $display("FAIL fault_duty: got %h want 0", dpwm_duty); end
    n_cmp++; if (dpwm_rst !== 1'b1) begin n_bad++; $display("FAIL fault_dpwm_rst: got %b want 1", dpwm_rst); end
    n_cmp++; if (cmd_if.duty_ready !== 1'b0) begin n_bad++; $display("FAIL fault_ready: got %b want 0", cmd_if.duty_ready); end
    n_cmp++; if (fault_latched !== 1'b1) begin n_bad++; $display("FAIL fault_latched_set: got %b want 1", fault_latched); end
    idle(3);
    n_cmp++; if (state !== 3'd4) begin n_bad++; $display("FAIL fault_sticky: got %0d want 4", state); end
    n_cmp++; if (fault_latched !== 1'b1) begin n_bad++; $display("FAIL fault_latched_hold: got %b want 1", fault_latched); end
    en = 1'b0;
    step();
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL fault_exit_state: got %0d want 0", state); end
    n_cmp++; if (fault_latched !== 1'b0) begin n_bad++; $display("FAIL fault_latched_clear: got %b want 0", fault_latched); end
    n_cmp++; if (cmd_if.duty_ready !== 1'b1) begin n_bad++; $display("FAIL fault_exit_ready: got %b want 1", cmd_if.duty_ready); end
  endtask

  task automatic test_rst_mid_run();
    send_cmd(0);
    en = 1'b1;
    step();
    idle(ARM_CYC);
    pulse_sync();
    n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL zero_target_run: got %0d want 3", state); end
    send_cmd(700);
    idle(1);
    pulse_sync();
    $display("rst_mid_run: cmd 700 applied, duty=%0d", cell_duty(1));
    n_cmp++; if (cell_duty(1) != 700) begin n_bad++; $display("FAIL pre_rst_duty: got %0d want 700", cell_duty(1)); end
    rst = 1'b0;
    step();
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL midrst_state: got %0d want 0", state); end
    n_cmp++; if (dpwm_rst !== 1'b1) begin n_bad++; $display("FAIL midrst_dpwm_rst: got %b want 1", dpwm_rst); end
    n_cmp++; if (gate_en !== 1'b0) begin n_bad++; $display("FAIL midrst_gate_en: got %b want 0", gate_en); end
    n_cmp++; if (dpwm_duty !== '0) begin n_bad++; $display("FAIL midrst_duty: got %h want 0", dpwm_duty); end
    n_cmp++; if (dpwm_angle !== '0) begin n_bad++; $display("FAIL midrst_angle: got %h want 0", dpwm_angle); end
    n_cmp++; if (cmd_if.duty_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_ready: got %b want 0", cmd_if.duty_ready); end
    rst = 1'b1;
    en = 1'b0;
    step();
    n_cmp++; if (cmd_if.duty_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_release_ready: got %b want 1", cmd_if.duty_ready); end
    en = 1'b1;
    step();
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL restart_arm: got %0d want 1", state); end
    n_cmp++; if (cell_angle(1) != PERIOD / N_CELLS) begin n_bad++; $display("FAIL restart_angle1: got %0d want %0d", cell_angle(1), PERIOD / N_CELLS); end
    en = 1'b0;
    step();
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL arm_abort_state: got %0d want 0", state); end
  endtask

  initial begin
    cmd_if.duty_cmd   = '0;
    cmd_if.duty_valid = 1'b0;
    test_reset();
    test_softstart(400);
    test_run_cmds();
    test_fault();
    test_rst_mid_run();
    test_softstart(int'($urandom_range(1, 30)) * SS_STEP - int'($urandom_range(0, SS_STEP - 1)));
    test_run_cmds();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
